// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Purpose : bundles the instruction/status inputs and control strobes that
//           connect the multicycle control unit to its datapath.
// Signals :
//   Instr         32          instruction from the instruction register
//   Zero          1           ALU zero flag
//   Mem_Ready     1           data-memory access complete
//   IR_LdEn       1           load instruction register
//   PC_Sel        1           0 = PC+4, 1 = branch target
//   PC_LdEn       1           load PC
//   RF_WrEn       1           register file write
//   RF_WrData_sel 1           0 = memory data, 1 = ALU result
//   RF_B_sel      1           B read-port select
//   ALU_Bin_sel   1           0 = register, 1 = immediate
//   ALU_func      ALU_FUNC_W  ALU operation
//   Mem_RdEn      1           data-memory read request
//   Mem_WrEn      1           data-memory write request
//   Byte_Op       1           byte access (lb/sb)
//   Mem_Err       1           sticky memory timeout flag
//   Instr_Count   CNT_W       retired instruction count
// Modports:
//   master - datapath side: drives Instr/Zero/Mem_Ready, receives strobes
//   slave  - control unit side: receives Instr/Zero/Mem_Ready, drives strobes
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int ALU_FUNC_W = 4,
  parameter int CNT_W      = 16
);
  logic [31:0]           Instr;
  logic                  Zero;
  logic                  Mem_Ready;
  logic                  IR_LdEn;
  logic                  PC_Sel;
  logic                  PC_LdEn;
  logic                  RF_WrEn;
  logic                  RF_WrData_sel;
  logic                  RF_B_sel;
  logic                  ALU_Bin_sel;
  logic [ALU_FUNC_W-1:0] ALU_func;
  logic                  Mem_RdEn;
  logic                  Mem_WrEn;
  logic                  Byte_Op;
  logic                  Mem_Err;
  logic [CNT_W-1:0]      Instr_Count;

  modport master (
    output Instr, Zero, Mem_Ready,
    input  IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, Mem_RdEn, Mem_WrEn, Byte_Op, Mem_Err,
           Instr_Count
  );

  modport slave (
    input  Instr, Zero, Mem_Ready,
    output IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, Mem_RdEn, Mem_WrEn, Byte_Op, Mem_Err,
           Instr_Count
  );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Purpose : control FSM of a multicycle CPU (IF -> DEC -> EXEC -> MEM/WB).
//           Strobes are combinational decodes of the state register and the
//           opcode/funct fields latched in DEC. Memory accesses are guarded by
//           a wait counter; an access that never completes sets the sticky
//           Mem_Err flag and retires the instruction without write-back.
// Ports   :
//   Clk     in  rising-edge clock
//   Reset_n in  asynchronous active-low reset
//   bus     multicycle_control_if.slave (Instr/Zero/Mem_Ready in, strobes,
//           Mem_Err and Instr_Count out)
// Parameters:
//   ALU_FUNC_W  width of ALU_func and the R-type funct field
//   CNT_W       width of the retired-instruction counter
//   MEM_TMO     cycles without Mem_Ready before an access is aborted
// Build option:
//   MC_ILLEGAL_TRAP_EN  unlisted opcodes lock the FSM in TRAP until reset;
//                       when undefined they execute as a 3-cycle NOP.
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int ALU_FUNC_W = 4,
  parameter int CNT_W      = 16,
  parameter int MEM_TMO    = 15
) (
  input logic Clk,
  input logic Reset_n,
  multicycle_control_if.slave bus
);

  localparam int WAIT_W = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  typedef enum logic [2:0] {
    S_IF,
    S_DEC,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t                r_state;
  logic [5:0]            r_opcode;
  logic [ALU_FUNC_W-1:0] r_func;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_memErr;
  logic [CNT_W-1:0]      r_instrCount;

  logic                  w_timeout;
  logic                  w_irLdEn;
  logic                  w_pcSel;
  logic                  w_pcLdEn;
  logic                  w_rfWrEn;
  logic                  w_rfWrDataSel;
  logic                  w_rfBSel;
  logic                  w_aluBinSel;
  logic [ALU_FUNC_W-1:0] w_aluFunc;
  logic                  w_memRdEn;
  logic                  w_memWrEn;
  logic                  w_byteOp;
  logic                  w_unusedInstr;

  function automatic logic isLoad(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic isBranch(input logic [5:0] op);
    return (op == OP_B) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic isAluOp(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic isLegal(input logic [5:0] op);
    return isLoad(op) || isStore(op) || isBranch(op) || isAluOp(op);
  endfunction

  // Stores read the data register and branches read the compare register
  // through the B port, so those opcodes steer RF_B_sel in DEC.
  function automatic logic usesRdAsB(input logic [5:0] op);
    return isStore(op) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic usesImm(input logic [5:0] op);
    return isLoad(op) || isStore(op) || (op == OP_ADDI) || (op == OP_LI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [ALU_FUNC_W-1:0] aluFuncOf(
    input logic [5:0]            op,
    input logic [ALU_FUNC_W-1:0] fn
  );
    logic [ALU_FUNC_W-1:0] f;
    f = '0;
    case (op)
      OP_RTYPE:       f = fn;
      OP_ANDI:        f = ALU_FUNC_W'(2);
      OP_ORI:         f = ALU_FUNC_W'(3);
      OP_BEQ, OP_BNE: f = ALU_FUNC_W'(1);
      default:        f = '0;
    endcase
    return f;
  endfunction

  // Only the opcode and funct fields matter to control; the rest of the
  // instruction word is reduced here so it is visibly accounted for.
  assign w_unusedInstr = ^bus.Instr;

  assign w_timeout = (r_wait == WAIT_W'(MEM_TMO));

  // Strobe decode. Everything defaults to 0 and each state raises only its
  // own strobes. Gating with Reset_n keeps IR_LdEn (state IF) from showing
  // while reset is held and kills a memory strobe the moment reset drops.
  always_comb begin
    w_irLdEn      = 1'b0;
    w_pcSel       = 1'b0;
    w_pcLdEn      = 1'b0;
    w_rfWrEn      = 1'b0;
    w_rfWrDataSel = 1'b0;
    w_rfBSel      = 1'b0;
    w_aluBinSel   = 1'b0;
    w_aluFunc     = '0;
    w_memRdEn     = 1'b0;
    w_memWrEn     = 1'b0;
    w_byteOp      = 1'b0;
    if (Reset_n) begin
      case (r_state)
        S_IF:  w_irLdEn = 1'b1;
        // The opcode is not latched until the end of DEC, so RF_B_sel
        // decodes the live instruction register.
        S_DEC: w_rfBSel = usesRdAsB(bus.Instr[31:26]);
        S_EXEC: begin
          w_aluFunc   = aluFuncOf(r_opcode, r_func);
          w_aluBinSel = usesImm(r_opcode);
          if (r_opcode == OP_B) begin
            w_pcLdEn = 1'b1;
            w_pcSel  = 1'b1;
          end else if (r_opcode == OP_BEQ) begin
            w_pcLdEn = 1'b1;
            w_pcSel  = bus.Zero;
          end else if (r_opcode == OP_BNE) begin
            w_pcLdEn = 1'b1;
            w_pcSel  = ~bus.Zero;
          end else if (!isLegal(r_opcode)) begin
            w_pcLdEn = 1'b1;
          end
        end
        S_MEM: begin
          w_memRdEn = isLoad(r_opcode);
          w_memWrEn = isStore(r_opcode);
          w_byteOp  = (r_opcode == OP_LB) || (r_opcode == OP_SB);
          // Ready wins over a coincident timeout; a store retires here,
          // a load moves on to WB. A timeout retires either kind.
          if (bus.Mem_Ready) begin
            w_pcLdEn = isStore(r_opcode);
          end else if (w_timeout) begin
            w_pcLdEn = 1'b1;
          end
        end
        S_WB: begin
          w_rfWrEn      = 1'b1;
          w_pcLdEn      = 1'b1;
          w_rfWrDataSel = ~isLoad(r_opcode);
        end
        default: ;
      endcase
    end
  end

  // State sequencing plus the latched fields, memory wait counter, sticky
  // error flag and retirement counter. Every instruction retires on its
  // single PC_LdEn cycle, so that strobe drives the counter directly.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IF;
      r_opcode     <= '0;
      r_func       <= '0;
      r_wait       <= '0;
      r_memErr     <= 1'b0;
      r_instrCount <= '0;
    end else begin
      if (w_pcLdEn) begin
        r_instrCount <= r_instrCount + CNT_W'(1);
      end
      case (r_state)
        S_IF: r_state <= S_DEC;
        S_DEC: begin
          r_opcode <= bus.Instr[31:26];
          r_func   <= bus.Instr[ALU_FUNC_W-1:0];
          r_state  <= S_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
          if (!isLegal(bus.Instr[31:26])) begin
            r_state <= S_TRAP;
          end
`endif
        end
        S_EXEC: begin
          r_wait <= '0;
          if (isLoad(r_opcode) || isStore(r_opcode)) begin
            r_state <= S_MEM;
          end else if (isAluOp(r_opcode)) begin
            r_state <= S_WB;
          end else begin
            r_state <= S_IF;
          end
        end
        S_MEM: begin
          if (bus.Mem_Ready) begin
            r_state <= isLoad(r_opcode) ? S_WB : S_IF;
          end else if (w_timeout) begin
            r_memErr <= 1'b1;
            r_state  <= S_IF;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB: r_state <= S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: r_state <= S_TRAP;
`endif
        default: r_state <= S_IF;
      endcase
    end
  end

  assign bus.IR_LdEn       = w_irLdEn;
  assign bus.PC_Sel        = w_pcSel;
  assign bus.PC_LdEn       = w_pcLdEn;
  assign bus.RF_WrEn       = w_rfWrEn;
  assign bus.RF_WrData_sel = w_rfWrDataSel;
  assign bus.RF_B_sel      = w_rfBSel;
  assign bus.ALU_Bin_sel   = w_aluBinSel;
  assign bus.ALU_func      = w_aluFunc;
  assign bus.Mem_RdEn      = w_memRdEn;
  assign bus.Mem_WrEn      = w_memWrEn;
  assign bus.Byte_Op       = w_byteOp;
  assign bus.Mem_Err       = r_memErr;
  assign bus.Instr_Count   = r_instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench for multicycle_control. For each instruction the expected
// per-cycle strobe vector is pushed into a queue from the instruction class,
// Zero and the Mem_Ready delay; the vectors are popped and compared against
// the DUT every cycle. A second instance with CNT_W=2 shares the same
// stimulus to exercise counter wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_BAD   = 6'b101010;

  logic clk;
  logic resetN;

  int checkCount;
  int errorCount;
  int expCount;
  logic expMemErr;
  logic [13:0] expQ[$];

  multicycle_control_if #(.ALU_FUNC_W(4), .CNT_W(16)) bus ();
  multicycle_control_if #(.ALU_FUNC_W(4), .CNT_W(2))  bus2 ();

  assign bus2.Instr     = bus.Instr;
  assign bus2.Zero      = bus.Zero;
  assign bus2.Mem_Ready = bus.Mem_Ready;

  multicycle_control #(.ALU_FUNC_W(4), .CNT_W(16), .MEM_TMO(15)) dut (
    .Clk     (clk),
    .Reset_n (resetN),
    .bus     (bus)
  );

  multicycle_control #(.ALU_FUNC_W(4), .CNT_W(2), .MEM_TMO(15)) dutSmall (
    .Clk     (clk),
    .Reset_n (resetN),
    .bus     (bus2)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison lands here so the counts and reporting stay uniform.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [13:0] mkVec(
    input logic irLd, input logic pcSel, input logic pcLd, input logic rfWr,
    input logic rfWd, input logic rfB, input logic bin, input logic [3:0] fn,
    input logic rd, input logic wr, input logic byteOp);
    return {irLd, pcSel, pcLd, rfWr, rfWd, rfB, bin, fn, rd, wr, byteOp};
  endfunction

  function automatic logic [13:0] observedVec();
    return {bus.IR_LdEn, bus.PC_Sel, bus.PC_LdEn, bus.RF_WrEn,
            bus.RF_WrData_sel, bus.RF_B_sel, bus.ALU_Bin_sel, bus.ALU_func,
            bus.Mem_RdEn, bus.Mem_WrEn, bus.Byte_Op};
  endfunction

  // Holds reset for two cycles checking that all strobes stay low, then
  // releases just after a rising edge so the current cycle is IF.
  task automatic doReset();
    resetN        = 1'b0;
    bus.Instr     = '0;
    bus.Zero      = 1'b0;
    bus.Mem_Ready = 1'b0;
    @(negedge clk);
    checkOutput("resetStrobes", 32'(observedVec()), 32'd0);
    checkOutput("resetMemErr", 32'(bus.Mem_Err), 32'd0);
    checkOutput("resetCount", 32'(bus.Instr_Count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN    = 1'b1;
    expCount  = 0;
    expMemErr = 1'b0;
  endtask

  // Builds the expected strobe sequence of one instruction, then drives it
  // cycle by cycle and compares. readyDelay is the number of MEM cycles
  // before Mem_Ready rises; stopAfter > 0 abandons the instruction early.
  task automatic applyStimulus(input string name, input logic [5:0] op,
                               input logic [3:0] fn, input logic zero,
                               input int readyDelay, input int stopAfter);
    logic [13:0] v;
    logic [3:0]  eFunc;
    logic        eBin, ePcLd, ePcSel, isLd, isSt, isByte, isAlu, isBr;
    logic        legal, timedOut, trap;
    int          memCycles;
    int          n;

    isLd   = (op == OP_LW) || (op == OP_LB);
    isSt   = (op == OP_SW) || (op == OP_SB);
    isByte = (op == OP_LB) || (op == OP_SB);
    isBr   = (op == OP_B) || (op == OP_BEQ) || (op == OP_BNE);
    isAlu  = op inside {OP_RTYPE, OP_ADDI, OP_LI, OP_ANDI, OP_ORI};
    legal  = isLd || isSt || isBr || isAlu;
    timedOut = (isLd || isSt) && (readyDelay > 15);
    trap   = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    trap   = !legal;
`endif

    expQ.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
    expQ.push_back(mkVec(0, 0, 0, 0, 0, isSt || op == OP_BEQ || op == OP_BNE,
                         0, 4'd0, 0, 0, 0));
    if (trap) begin
      repeat (4) expQ.push_back(14'd0);
    end else begin
      eFunc = 4'd0; eBin = 1'b0; ePcLd = 1'b0; ePcSel = 1'b0;
      case (op)
        OP_RTYPE: eFunc = fn;
        OP_ADDI, OP_LI, OP_LW, OP_LB, OP_SW, OP_SB: eBin = 1'b1;
        OP_ANDI: begin eFunc = 4'd2; eBin = 1'b1; end
        OP_ORI:  begin eFunc = 4'd3; eBin = 1'b1; end
        OP_BEQ:  begin eFunc = 4'd1; ePcLd = 1'b1; ePcSel = zero; end
        OP_BNE:  begin eFunc = 4'd1; ePcLd = 1'b1; ePcSel = !zero; end
        OP_B:    begin ePcLd = 1'b1; ePcSel = 1'b1; end
        default: ePcLd = 1'b1;
      endcase
      expQ.push_back(mkVec(0, ePcSel, ePcLd, 0, 0, 0, eBin, eFunc, 0, 0, 0));
      if (isLd || isSt) begin
        memCycles = timedOut ? 16 : readyDelay + 1;
        for (int i = 0; i < memCycles; i++) begin
          expQ.push_back(mkVec(0, 0, (i == memCycles - 1) && (isSt || timedOut),
                               0, 0, 0, 0, 4'd0, isLd, isSt, isByte));
        end
      end
      if ((isLd && !timedOut) || isAlu) begin
        expQ.push_back(mkVec(0, 0, 1, 1, isAlu, 0, 0, 4'd0, 0, 0, 0));
      end
    end

    bus.Instr = {op, 22'h2A5A5, fn};
    bus.Zero  = zero;
    n = 0;
    while (expQ.size() > 0 && (stopAfter == 0 || n < stopAfter)) begin
      bus.Mem_Ready = (isLd || isSt) && (n == 3 + readyDelay);
      @(negedge clk);
      v = expQ.pop_front();
      checkOutput($sformatf("%s c%0d", name, n + 1), 32'(observedVec()), 32'(v));
      @(posedge clk);
      #1;
      n++;
    end
    bus.Mem_Ready = 1'b0;
    if (stopAfter == 0 && !trap) begin
      expCount++;
      if (timedOut) expMemErr = 1'b1;
    end
    expQ.delete();
  endtask

  // Post-instruction state: retirement count and sticky error flag.
  task automatic checkState(input string name);
    checkOutput({name, " count"}, 32'(bus.Instr_Count), 32'(expCount % 65536));
    checkOutput({name, " memErr"}, 32'(bus.Mem_Err), 32'(expMemErr));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    doReset();

    applyStimulus("addi", OP_ADDI, 4'd9, 1'b0, 0, 0);    checkState("addi");
    applyStimulus("rtype", OP_RTYPE, 4'd5, 1'b0, 0, 0);  checkState("rtype");
    applyStimulus("andi", OP_ANDI, 4'd0, 1'b0, 0, 0);    checkState("andi");
    applyStimulus("ori", OP_ORI, 4'd7, 1'b1, 0, 0);      checkState("ori");
    applyStimulus("beqZ1", OP_BEQ, 4'd0, 1'b1, 0, 0);    checkState("beqZ1");
    applyStimulus("bneZ1", OP_BNE, 4'd0, 1'b1, 0, 0);    checkState("bneZ1");
    applyStimulus("beqZ0", OP_BEQ, 4'd0, 1'b0, 0, 0);    checkState("beqZ0");
    applyStimulus("b", OP_B, 4'd0, 1'b0, 0, 0);          checkState("b");
    applyStimulus("lbWait3", OP_LB, 4'd0, 1'b0, 3, 0);   checkState("lbWait3");
    applyStimulus("lw", OP_LW, 4'd0, 1'b0, 0, 0);        checkState("lw");
    applyStimulus("swWait2", OP_SW, 4'd0, 1'b0, 2, 0);   checkState("swWait2");
    applyStimulus("sb", OP_SB, 4'd0, 1'b0, 0, 0);        checkState("sb");
    applyStimulus("li", OP_LI, 4'd0, 1'b0, 0, 0);        checkState("li");
    applyStimulus("swTmo", OP_SW, 4'd0, 1'b0, 100, 0);   checkState("swTmo");
    applyStimulus("lwEdge", OP_LW, 4'd0, 1'b0, 15, 0);   checkState("lwEdge");
    applyStimulus("lbTmo", OP_LB, 4'd0, 1'b0, 100, 0);   checkState("lbTmo");

    checkOutput("wrapCount", 32'(bus2.Instr_Count), 32'(expCount % 4));

    applyStimulus("illegal", OP_BAD, 4'd0, 1'b0, 0, 0);  checkState("illegal");
    checkOutput("wrapCountPost", 32'(bus2.Instr_Count), 32'(expCount % 4));

    doReset();
    applyStimulus("addiPostRst", OP_ADDI, 4'd0, 1'b0, 0, 0);
    checkState("addiPostRst");

    // Abandon a store three cycles into MEM by dropping reset mid-cycle.
    applyStimulus("swAbort", OP_SW, 4'd0, 1'b0, 100, 6);
    checkOutput("abortWrEnBefore", 32'(bus.Mem_WrEn), 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("abortWrEn", 32'(bus.Mem_WrEn), 32'd0);
    checkOutput("abortStrobes", 32'(observedVec()), 32'd0);
    checkOutput("abortCount", 32'(bus.Instr_Count), 32'd0);
    checkOutput("abortCountSmall", 32'(bus2.Instr_Count), 32'd0);
    checkOutput("abortMemErr", 32'(bus.Mem_Err), 32'd0);
    doReset();
    applyStimulus("bAfterAbort", OP_B, 4'd0, 1'b0, 0, 0);
    checkState("bAfterAbort");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
